// File: rtl/cpu_loader_pkg.sv
// Shared types and constants for the CPU program/data loader.
// Holds the FSM state enum, halt opcodes and header bit positions.
package cpu_loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_ADDR,
    ST_CNT,
    ST_DATA,
    ST_HOLD,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } loader_state_t;

  // Registered control outputs that depend only on the state being entered.
  typedef struct packed {
    logic ready;
    logic cpu_rst;
    logic done;
  } loader_flags_t;

  localparam logic [15:0] HALT_OP_A = 16'hE000;
  localparam logic [15:0] HALT_OP_B = 16'hE7FF;

  localparam int HDR_LAST = 15;
  localparam int HDR_TGT  = 14;

  function automatic logic hdr_malformed(input logic [15:0] word);
    return word[13:0] != 14'd0;
  endfunction

  function automatic loader_flags_t state_flags(input loader_state_t s);
    loader_flags_t f;
    f.ready   = (s == ST_HDR) || (s == ST_ADDR) || (s == ST_CNT) || (s == ST_DATA);
    f.cpu_rst = !((s == ST_RUN) || (s == ST_FLUSH) || (s == ST_DONE));
    f.done    = (s == ST_DONE);
    return f;
  endfunction

endpackage

// File: rtl/cpu_halt_detect.sv
// Combinational match of the fetched instruction against both halt encodings.
// Kept separate so debug logic can reuse the same decode.
module cpu_halt_detect
  import cpu_loader_pkg::*;
(
  input  logic [15:0] instr,
  output logic        halt
);

  assign halt = (instr == HALT_OP_A) || (instr == HALT_OP_B);

endmodule

// File: rtl/cpu_loader.sv
// Framed-stream program/data loader and run controller for the 16-bit cpu.
// Loads memories with the CPU held in reset, releases it, and times the run to halt.
module cpu_loader
  import cpu_loader_pkg::*;
#(
  parameter int RESET_HOLD = 4,
  parameter int PIPE_FLUSH = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  output logic        imem_we,
  output logic        dmem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        cpu_reset,
  input  logic [15:0] instr,
  output logic        halted,
  output logic        load_err,
  output logic [31:0] run_cycles
);

  loader_state_t state;
  loader_flags_t flags;
  logic          last_seg;
  logic          tgt_dmem;
  logic [15:0]   addr;
  logic [15:0]   remaining;
  logic [31:0]   delay_cnt;
  logic          halt_hit;
  logic          accept;

  assign accept    = s_valid & s_ready;
  assign s_ready   = flags.ready;
  assign cpu_reset = flags.cpu_rst;
  assign halted    = flags.done;

  cpu_halt_detect u_halt_detect (
    .instr (instr),
    .halt  (halt_hit)
  );

  // Flags are loaded alongside every state change so the control outputs stay registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_HDR;
      flags      <= state_flags(ST_HDR);
      load_err   <= 1'b0;
      imem_we    <= 1'b0;
      dmem_we    <= 1'b0;
      mem_addr   <= 16'd0;
      mem_wdata  <= 16'd0;
      run_cycles <= 32'd0;
      addr       <= 16'd0;
      remaining  <= 16'd0;
      delay_cnt  <= 32'd0;
      last_seg   <= 1'b0;
      tgt_dmem   <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      dmem_we <= 1'b0;
      case (state)
        ST_HDR: begin
          if (accept) begin
            if (hdr_malformed(s_data)) begin
              load_err <= 1'b1;
            end else begin
              last_seg <= s_data[HDR_LAST];
              tgt_dmem <= s_data[HDR_TGT];
              state    <= ST_ADDR;
              flags    <= state_flags(ST_ADDR);
            end
          end
        end
        ST_ADDR: begin
          if (accept) begin
            addr  <= s_data;
            state <= ST_CNT;
            flags <= state_flags(ST_CNT);
          end
        end
        ST_CNT: begin
          if (accept) begin
            remaining <= s_data;
            delay_cnt <= 32'd0;
            if (s_data != 16'd0) begin
              state <= ST_DATA;
              flags <= state_flags(ST_DATA);
            end else if (last_seg) begin
              state <= ST_HOLD;
              flags <= state_flags(ST_HOLD);
            end else begin
              state <= ST_HDR;
              flags <= state_flags(ST_HDR);
            end
          end
        end
        ST_DATA: begin
          if (accept) begin
            imem_we   <= !tgt_dmem;
            dmem_we   <= tgt_dmem;
            mem_addr  <= addr;
            mem_wdata <= s_data;
            addr      <= addr + 16'd1;
            remaining <= remaining - 16'd1;
            delay_cnt <= 32'd0;
            if (remaining == 16'd1) begin
              if (last_seg) begin
                state <= ST_HOLD;
                flags <= state_flags(ST_HOLD);
              end else begin
                state <= ST_HDR;
                flags <= state_flags(ST_HDR);
              end
            end
          end
        end
        ST_HOLD: begin
          if (delay_cnt == 32'(RESET_HOLD - 1)) begin
            delay_cnt <= 32'd0;
            state     <= ST_RUN;
            flags     <= state_flags(ST_RUN);
          end else begin
            delay_cnt <= delay_cnt + 32'd1;
          end
        end
        ST_RUN: begin
          run_cycles <= run_cycles + 32'd1;
          if (halt_hit) begin
            delay_cnt <= 32'd0;
            state     <= ST_FLUSH;
            flags     <= state_flags(ST_FLUSH);
          end
        end
        ST_FLUSH: begin
          run_cycles <= run_cycles + 32'd1;
          if (delay_cnt == 32'(PIPE_FLUSH - 1)) begin
            state <= ST_DONE;
            flags <= state_flags(ST_DONE);
          end else begin
            delay_cnt <= delay_cnt + 32'd1;
          end
        end
        ST_DONE: begin
        end
        default: begin
          state <= ST_HDR;
          flags <= state_flags(ST_HDR);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_loader.sv
// Self-checking bench for cpu_loader: random framed loads checked against a write-list model,
// plus release timing, halt timing and reset-abort scenarios.
module tb_cpu_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        imem_we;
  logic        dmem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_reset;
  logic [15:0] instr;
  logic        halted;
  logic        load_err;
  logic [31:0] run_cycles;

  typedef struct packed {
    logic        dmem;
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t obsWr[$];
  wr_t expWr[$];
  int  dualStrobe = 0;
  int  errors = 0;
  int  checks = 0;

  cpu_loader #(.RESET_HOLD(4), .PIPE_FLUSH(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .imem_we    (imem_we),
    .dmem_we    (dmem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_reset  (cpu_reset),
    .instr      (instr),
    .halted     (halted),
    .load_err   (load_err),
    .run_cycles (run_cycles)
  );

  always #5 clk = ~clk;

  // Write strobes are collected mid-cycle, so each one-cycle pulse is recorded exactly once.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (imem_we || dmem_we) begin
        w.dmem = dmem_we;
        w.addr = mem_addr;
        w.data = mem_wdata;
        obsWr.push_back(w);
      end
      if (imem_we && dmem_we) dualStrobe++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] nonHalt();
    logic [15:0] v;
    do v = 16'($urandom); while (v == 16'hE000 || v == 16'hE7FF);
    return v;
  endfunction

  task automatic applyReset();
    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = 16'd0;
    instr   = 16'd0;
    tick();
    tick();
    reset = 1'b0;
    obsWr.delete();
    expWr.delete();
  endtask

  // Returns at #1 after the edge that accepted the word.
  task automatic sendWord(input logic [15:0] w, input int gapMax);
    int gaps;
    int budget;
    logic rdy;
    gaps = $urandom_range(gapMax, 0);
    s_valid = 1'b0;
    for (int g = 0; g < gaps; g++) tick();
    s_valid = 1'b1;
    s_data  = w;
    budget  = 0;
    do begin
      rdy = s_ready;
      tick();
      budget++;
    end while (!rdy && budget < 50);
    if (!rdy) checkOutput("ready_timeout", 64'd0, 64'd1);
    s_valid = 1'b0;
    s_data  = 16'($urandom);
  endtask

  task automatic sendSegment(input logic last, input logic tgt, input logic [15:0] base,
                             input logic [15:0] data[$], input int gapMax);
    wr_t w;
    sendWord({last, tgt, 14'd0}, gapMax);
    sendWord(base, gapMax);
    sendWord(16'(data.size()), gapMax);
    for (int i = 0; i < data.size(); i++) begin
      w.dmem = tgt;
      w.addr = base + 16'(i);
      w.data = data[i];
      expWr.push_back(w);
      sendWord(data[i], gapMax);
    end
  endtask

  // Called in the cycle right after the final accept of a last segment.
  task automatic checkRelease(input string tag);
    checkOutput({tag, "_ready_in_hold"}, 64'(s_ready), 64'd0);
    checkOutput({tag, "_cpu_reset_hold0"}, 64'(cpu_reset), 64'd1);
    repeat (3) tick();
    checkOutput({tag, "_cpu_reset_hold3"}, 64'(cpu_reset), 64'd1);
    tick();
    checkOutput({tag, "_cpu_reset_release"}, 64'(cpu_reset), 64'd0);
  endtask

  task automatic compareWrites(input string tag);
    int n;
    checkOutput({tag, "_write_count"}, 64'(obsWr.size()), 64'(expWr.size()));
    n = (obsWr.size() < expWr.size()) ? obsWr.size() : expWr.size();
    for (int i = 0; i < n; i++) checkOutput({tag, "_write"}, 64'(obsWr[i]), 64'(expWr[i]));
    obsWr.delete();
    expWr.delete();
  endtask

  // Expects to start in RUN cycle 1; the halt opcode is presented on RUN cycle k.
  task automatic runAndHalt(input string tag, input int k, input logic [15:0] op);
    for (int c = 1; c < k; c++) begin
      instr = nonHalt();
      tick();
    end
    instr = op;
    tick();
    instr = nonHalt();
    repeat (9) tick();
    checkOutput({tag, "_halted_early"}, 64'(halted), 64'd0);
    tick();
    checkOutput({tag, "_halted"}, 64'(halted), 64'd1);
    checkOutput({tag, "_run_cycles"}, 64'(run_cycles), 64'(k + 10));
    instr = op;
    repeat (5) tick();
    checkOutput({tag, "_run_cycles_frozen"}, 64'(run_cycles), 64'(k + 10));
    checkOutput({tag, "_halted_held"}, 64'(halted), 64'd1);
    checkOutput({tag, "_cpu_reset_low"}, 64'(cpu_reset), 64'd0);
    instr = 16'd0;
  endtask

  // Random multi-segment frame, occasionally preceded by malformed headers.
  task automatic applyStimulus(output logic expErr);
    int nseg;
    int cnt;
    logic [15:0] bad;
    logic [15:0] data[$];
    expErr = 1'b0;
    nseg = $urandom_range(3, 1);
    for (int s = 0; s < nseg; s++) begin
      if ($urandom_range(3, 0) == 0) begin
        bad = {2'($urandom), 14'($urandom_range(16383, 1))};
        sendWord(bad, 1);
        expErr = 1'b1;
      end
      cnt = $urandom_range(4, 0);
      data.delete();
      for (int i = 0; i < cnt; i++) data.push_back(16'($urandom));
      sendSegment(s == nseg - 1, 1'($urandom), 16'($urandom), data, 2);
    end
  endtask

  initial begin
    logic [15:0] data[$];
    logic        expErr;
    wr_t         w;
    logic [15:0] op;

    applyReset();
    checkOutput("rst_state_ready", 64'(s_ready), 64'd1);
    checkOutput("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    checkOutput("rst_imem_we", 64'(imem_we), 64'd0);
    checkOutput("rst_dmem_we", 64'(dmem_we), 64'd0);
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    checkOutput("rst_halted", 64'(halted), 64'd0);
    checkOutput("rst_load_err", 64'(load_err), 64'd0);
    checkOutput("rst_run_cycles", 64'(run_cycles), 64'd0);

    $display("[TB] single imem segment");
    data = '{16'h00A1, 16'h00A2, 16'h00A3};
    sendSegment(1'b1, 1'b0, 16'h0010, data, 0);
    checkOutput("t1_imem_we_latency", 64'(imem_we), 64'd1);
    checkOutput("t1_mem_addr_last", 64'(mem_addr), 64'h12);
    checkOutput("t1_mem_wdata_last", 64'(mem_wdata), 64'hA3);
    checkRelease("t1");
    compareWrites("t1");
    runAndHalt("t1", 20, 16'hE7FF);

    $display("[TB] bad header then two throttled segments");
    applyReset();
    sendWord(16'h0001, 0);
    checkOutput("t2_load_err", 64'(load_err), 64'd1);
    checkOutput("t2_still_hdr", 64'(s_ready), 64'd1);
    data = '{16'd1, 16'd2, 16'd3};
    sendSegment(1'b0, 1'b1, 16'hFFFE, data, 2);
    data.delete();
    for (int i = 0; i < $urandom_range(5, 1); i++) data.push_back(16'($urandom));
    sendSegment(1'b1, 1'b0, 16'($urandom), data, 2);
    checkRelease("t2");
    compareWrites("t2");
    checkOutput("t2_load_err_sticky", 64'(load_err), 64'd1);
    op = $urandom_range(1, 0) ? 16'hE000 : 16'hE7FF;
    runAndHalt("t2", $urandom_range(40, 1), op);

    $display("[TB] reset in mid-data");
    applyReset();
    sendWord(16'h0000, 0);
    sendWord(16'h0100, 0);
    sendWord(16'd3, 0);
    sendWord(16'h5555, 0);
    w.dmem = 1'b0;
    w.addr = 16'h0100;
    w.data = 16'h5555;
    expWr.push_back(w);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("t3_cpu_reset", 64'(cpu_reset), 64'd1);
    checkOutput("t3_ready_hdr", 64'(s_ready), 64'd1);
    checkOutput("t3_run_cycles", 64'(run_cycles), 64'd0);
    checkOutput("t3_mem_addr", 64'(mem_addr), 64'd0);
    repeat (6) tick();
    compareWrites("t3");

    $display("[TB] zero count with last set");
    sendWord(16'h8000, 0);
    sendWord(16'($urandom), 0);
    sendWord(16'd0, 0);
    checkRelease("t4");
    compareWrites("t4");
    runAndHalt("t4", 3, 16'hE000);

    $display("[TB] random frames");
    for (int it = 0; it < 6; it++) begin
      applyReset();
      applyStimulus(expErr);
      checkRelease("rnd");
      compareWrites("rnd");
      checkOutput("rnd_load_err", 64'(load_err), 64'(expErr));
      op = $urandom_range(1, 0) ? 16'hE000 : 16'hE7FF;
      runAndHalt("rnd", $urandom_range(10, 1), op);
    end

    checkOutput("dual_strobe", 64'(dualStrobe), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_loader.md
# cpu_loader

Hardware program/data loader and run controller for the 16-bit pipelined `cpu`. It holds the CPU in reset while it accepts a framed word stream and writes it into instruction or data memory. It then releases the CPU and watches the fetched instruction for a halt opcode. After a fixed pipeline-drain delay it reports completion with a cycle count. It sits between the host/test interface and the CPU's memory write ports.

## Interface
Parameters:
- `RESET_HOLD`, 4: cycles `cpu_reset` stays high after the last memory write.
- `PIPE_FLUSH`, 10: cycles between halt detection and `halted`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `s_valid` in 1: stream word valid.
- `s_ready` out 1: loader accepts a word.
- `s_data` in 16: stream word.
- `imem_we` out 1: instruction-memory write strobe.
- `dmem_we` out 1: data-memory write strobe.
- `mem_addr` out 16: write address.
- `mem_wdata` out 16: write data.
- `cpu_reset` out 1: reset to the CPU.
- `instr` in 16: CPU's currently fetched instruction.
- `halted` out 1: run complete; a level signal.
- `load_err` out 1: sticky; set when a header is malformed.
- `run_cycles` out 32: cycles spent in RUN and FLUSH.

## Operation
- A transfer is accepted on any rising edge where `s_valid & s_ready`.
- **Frame format:** header word `{last[15], target[14], 14'b0}`, then base address, then count, then `count` data words. `target` selects memory: 0 = imem, 1 = dmem.
- **States:** HDR, ADDR, CNT, DATA, HOLD, RUN, FLUSH, DONE.
- `s_ready` = 1 only in HDR, ADDR, CNT and DATA.
- **HDR:** if bits 13:0 are nonzero, set `load_err`, discard the word and stay in HDR. Otherwise latch `last` and `target`, then go to ADDR.
- **ADDR:** latch the base into the address register, then go to CNT.
- **CNT:** latch the count.
  - Count 0 with `last` = 0 goes to HDR.
  - Count 0 with `last` = 1 goes to HOLD.
  - Otherwise go to DATA.
- **DATA:** each accepted word produces one write strobe on the selected memory. The address post-increments and wraps from 0xFFFF to 0x0000. The remaining count decrements. When the final word is accepted, go to HDR, or to HOLD if `last` is set.
- **HOLD:** `cpu_reset` = 1 for `RESET_HOLD` cycles, then go to RUN.
- **RUN:** `cpu_reset` = 0 and `run_cycles` increments every cycle. If `instr` equals 16'hE000 or 16'hE7FF (opcode 11100 halt forms), go to FLUSH.
- **FLUSH:** `run_cycles` keeps counting. After `PIPE_FLUSH` cycles go to DONE.
- **DONE:** `halted` = 1 and `run_cycles` is frozen. The block stays in DONE until `reset`.
- `cpu_reset` = 1 in every state except RUN, FLUSH and DONE. The CPU keeps its halted state in DONE.
- `s_valid` while `s_ready` = 0 is ignored; the word is not consumed.

## Timing
- **Reset (synchronous), output values on the following cycle:**
  - State HDR, `s_ready` = 1, `cpu_reset` = 1.
  - `imem_we` = `dmem_we` = 0; `mem_addr` = `mem_wdata` = 0.
  - `halted` = 0, `load_err` = 0, `run_cycles` = 0.
- **Reset in mid-frame or mid-run** aborts to HDR. Partial writes already issued stay in memory.
- **Write latency:** `imem_we`/`dmem_we`, `mem_addr` and `mem_wdata` are registered. They are valid the cycle after the data handshake, with the strobe high for exactly one cycle. Back-to-back accepts give back-to-back strobes.
- **HOLD timing:** HOLD is entered the cycle after the last data accept. `cpu_reset` falls exactly `RESET_HOLD` cycles after HOLD entry.
- **Halt timing:** with a halt match on cycle N in RUN, FLUSH occupies cycles N+1..N+`PIPE_FLUSH`. `halted` rises on N+`PIPE_FLUSH`+1.
- **`run_cycles`** equals the total number of cycles spent in RUN plus FLUSH.
- **`load_err`** is set the cycle after the bad header is accepted. It stays set until `reset`.
- **No timeout:** a CPU that never halts stays in RUN indefinitely.

## Structure
- `cpu_loader_pkg` holds:
  - the state enum `loader_state_t`;
  - `HALT_OP_A` = 16'hE000 and `HALT_OP_B` = 16'hE7FF;
  - header bit positions `HDR_LAST` = 15 and `HDR_TGT` = 14.
- Sub-module `cpu_halt_detect`: combinational match of `instr` against both halt constants. It is shared with future debug logic.
- The main FSM, counters and write register stage live in `cpu_loader`.

## Test plan
- **Single imem segment:** stream header 16'h8000, base 0x0010, count 3, data 0xA1,0xA2,0xA3. Expect `imem_we` pulses at addresses 0x10, 0x11, 0x12 with matching data. `cpu_reset` falls 4 cycles after HOLD entry.
- **Two segments, with throttling:** dmem segment with header 16'h4000, base 0xFFFE, count 3, data 1,2,3, then an imem last segment. Expect `dmem_we` at 0xFFFE, 0xFFFF, 0x0000. `s_valid` gaps cause no extra strobes.
- **Bad header:** send 16'h0001. Expect `load_err` = 1, the word dropped and the loader still in HDR. A following valid frame loads normally.
- **Halt detection:** after release, drive `instr` = 16'hE7FF on RUN cycle 20. Expect `halted` = 1 exactly 11 cycles later and `run_cycles` = 30 (20 RUN cycles + 10 FLUSH).
- **Reset mid-DATA:** assert `reset` after 1 of 3 data words. Expect `cpu_reset` = 1, state HDR, no further strobes and counters cleared.
- **Zero count, last set:** header 16'h8000, any base, count 0. Expect no write strobes and HOLD entered the next cycle.
